// File: rtl/mmm_bitserial.sv
// Bit-serial Montgomery multiplier: p = a*b*2^-WIDTH mod n, one bit of a per cycle.
// Define MMM_FINAL_SUB_EN for a fully reduced result (p < n); otherwise p < 2n.
module mmm_bitserial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_r_reg;
    logic [WIDTH-1:0] n_r_reg;
    logic [WIDTH+1:0] acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH:0]   p_reg;

    logic [WIDTH+1:0] t_sum;
    logic [WIDTH+1:0] u_sum;
    logic [WIDTH+1:0] acc_step;
    logic             last_step;

    // acc < 2n and b < n keep u_sum below 4n, so WIDTH+2 bits suffice.
    always_comb begin
        t_sum    = acc_reg + (a_sh_reg[0] ? {2'b00, b_r_reg} : '0);
        u_sum    = t_sum + (t_sum[0] ? {2'b00, n_r_reg} : '0);
        acc_step = u_sum >> 1;
    end

    assign last_step = (cnt_reg == CW'(WIDTH - 1));

`ifdef MMM_FINAL_SUB_EN
    logic [WIDTH+1:0] acc_sub;

    always_comb begin
        acc_sub = acc_reg;
        if (acc_reg >= {2'b00, n_r_reg}) begin
            acc_sub = acc_reg - {2'b00, n_r_reg};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_r_reg   <= '0;
            n_r_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            p_reg     <= '0;
        end else if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_r_reg   <= b;
                        n_r_reg   <= n;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg  <= acc_step;
                    a_sh_reg <= a_sh_reg >> 1;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_step) begin
`ifdef MMM_FINAL_SUB_EN
                        state_reg <= SUB;
`else
                        // Result goes out in redundant form; p is loaded on entry to DONE.
                        p_reg     <= acc_step[WIDTH:0];
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
`endif
                    end
                end
`ifdef MMM_FINAL_SUB_EN
                SUB: begin
                    acc_reg   <= acc_sub;
                    p_reg     <= acc_sub[WIDTH:0];
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
`endif
                DONE: begin
                    p_reg     <= acc_reg[WIDTH:0];
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign p    = p_reg;

endmodule

// File: tb/tb_mmm_bitserial.sv
// Scoreboard bench for mmm_bitserial: stimulus pushes expected results and done cycle,
// a negedge monitor pops on each rising done.
module tb_mmm_bitserial;

    localparam int W = 8;
`ifdef MMM_FINAL_SUB_EN
    localparam int LAT    = W + 1;
    localparam int PERIOD = W + 3;
`else
    localparam int LAT    = W;
    localparam int PERIOD = W + 2;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         ena   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] n     = 8'd1;
    logic         busy;
    logic         done;
    logic [W:0]   p;

    mmm_bitserial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int exp_p;
        int nmod;
        int due;
        int id;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: one pop per rising done, checks arrival cycle, busy and result.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: done at cycle %0d with p=%0d, required no result", cyc, p);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("done_cycle op%0d", e.id), cyc, e.due);
                    check($sformatf("busy_at_done op%0d", e.id), int'(busy), 0);
`ifdef MMM_FINAL_SUB_EN
                    check($sformatf("p op%0d", e.id), int'(p), e.exp_p);
`else
                    vectors++;
                    if ((int'(p) % e.nmod) != e.exp_p || int'(p) >= 2 * e.nmod) begin
                        miscompares++;
                        $display("FAIL p op%0d: got %0d, required congruent to %0d mod %0d and below %0d",
                                 e.id, p, e.exp_p, e.nmod, 2 * e.nmod);
                    end
`endif
                end
            end
            done_prev = done;
        end
    end

    task automatic launch(input int av, input int bv, input int nv, input int expv,
                          input int extra, input int id, input bit push);
        exp_t e;
        a     = W'(av);
        b     = W'(bv);
        n     = W'(nv);
        start = 1'b1;
        if (push) begin
            e.exp_p = expv;
            e.nmod  = nv;
            e.due   = cyc + 1 + LAT + extra;
            e.id    = id;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int   acc_tab [8];
        int   c0;
        exp_t e;
        acc_tab = '{10, 5, 6, 3, 8, 4, 2, 1};

        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_p", int'(p), 0);
        rst = 1'b0;
        @(negedge clk);

        // 5*7*2^-8 mod 13 = 1, with the accumulator trajectory from the hand trace.
        launch(5, 7, 13, 1, 0, 1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("acc_iter%0d", i + 1), int'(dut.acc_reg), acc_tab[i]);
        end
        wait_drain();

        // n = 255 makes 2^-8 = 1, so the result is a*b mod 255.
        launch(254, 254, 255, 1, 0, 2, 1'b1);
        wait_drain();
        launch(100, 200, 255, 110, 0, 3, 1'b1);
        wait_drain();
        launch(3, 4, 13, 10, 0, 4, 1'b1);
        wait_drain();
        launch(0, 77, 13, 0, 0, 5, 1'b1);
        wait_drain();

        // start held high: a new operation every PERIOD cycles.
        a     = '0;
        b     = 8'd200;
        n     = 8'd13;
        start = 1'b1;
        c0    = cyc;
        for (int k = 0; k < 3; k++) begin
            e.exp_p = 0;
            e.nmod  = 13;
            e.due   = c0 + 1 + k * PERIOD + LAT;
            e.id    = 6 + k;
            sb.push_back(e);
        end
        repeat (2 * PERIOD + 1) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // start pulsed mid-operation with other operands must be ignored.
        launch(12, 12, 13, 3, 0, 9, 1'b1);
        for (int k = 0; k < LAT - 1; k++) begin
            check($sformatf("busy_calc_step%0d", k), int'(busy), 1);
            start = (k == 2);
            if (k == 2) begin
                a = 8'd5;
                b = 8'd7;
                n = 8'd13;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();
        repeat (PERIOD + 2) @(negedge clk);

        // Three cycles of ena low mid-CALC stretch latency by three.
        launch(100, 200, 255, 110, 3, 10, 1'b1);
        repeat (2) @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        wait_drain();

        // Reset at CALC step 4 abandons the operation.
        launch(3, 4, 13, 10, 0, 11, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_p", int'(p), 0);
        rst = 1'b0;
        @(negedge clk);
        launch(5, 7, 13, 1, 0, 12, 1'b1);
        wait_drain();
        repeat (PERIOD) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
